// File: rtl/rsa_pkg.sv
// Shared state encodings for the modular exponentiator and its bit-serial multiplier.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    MUL,
    SQR,
    FIN
  } modexp_state_t;

  typedef enum logic {
    MM_IDLE,
    MM_RUN
  } modmul_state_t;

endpackage

// File: rtl/modexp_modmul.sv
// Interleaved shift-add modular multiplier: p = a*b mod n, one bit of b per cycle, MSB first.
// The final-iteration product is presented combinationally on p alongside the done pulse.
module modmul
  import rsa_pkg::*;
#(
  parameter int mbit = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [mbit:0] a,
  input  logic [mbit:0] b,
  input  logic [mbit:0] n,
  output logic          done,
  output logic [mbit:0] p
);

  localparam int W  = mbit + 1;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  modmul_state_t state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, n_q, n_d, p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W+1:0] sum, red1, red2, nExt;

  // With a, p < n the sum stays below 3n, so two conditional subtracts restore p < n.
  always_comb begin
    nExt = {2'b00, n_q};
    sum  = {1'b0, p_q, 1'b0} + (b_q[W-1] ? {2'b00, a_q} : '0);
    red1 = (sum  >= nExt) ? sum  - nExt : sum;
    red2 = (red1 >= nExt) ? red1 - nExt : red1;
  end

  assign done = (state_q == MM_RUN) && (cnt_q == CNT_ONE);
  assign p    = red2[W-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      MM_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          n_d     = n;
          p_d     = '0;
          cnt_d   = CNT_INIT;
          state_d = MM_RUN;
        end
      end
      MM_RUN: begin
        p_d   = red2[W-1:0];
        b_d   = b_q << 1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = MM_IDLE;
      end
      default: state_d = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MM_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/modexp.sv
// Right-to-left square-and-multiply modular exponentiator (res = base^exp mod n).
// Define MODEXP_CONST_TIME_EN to process every exponent bit with a fixed latency.
module modexp
  import rsa_pkg::*;
#(
  parameter int mbit = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [mbit:0] base,
  input  logic [mbit:0] exp,
  input  logic [mbit:0] n,
  output logic          busy,
  output logic          done,
  output logic [mbit:0] res,
  output logic          err
);

  localparam int W = mbit + 1;
  localparam logic [W-1:0] ONE = W'(1);

  modexp_state_t state_q, state_d;
  logic [W-1:0]  acc_q, acc_d, b_q, b_d, exp_q, exp_d, n_q, n_d, res_q, res_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          issued_q, issued_d;
  logic [W-1:0]  remaining;

  logic          mmStart, mmDone;
  logic [W-1:0]  mmA, mmB, mmP;

`ifdef MODEXP_CONST_TIME_EN
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
  logic [CW-1:0] bitCnt_q, bitCnt_d;
`endif

  modmul #(.mbit(mbit)) uModmul (
    .clk  (clk),
    .rst  (rst),
    .start(mmStart),
    .a    (mmA),
    .b    (mmB),
    .n    (n_q),
    .done (mmDone),
    .p    (mmP)
  );

  assign remaining = exp_q >> 1;

  // Reduction feeds base in as the multiplier so that base >= n is still reduced correctly.
  always_comb begin
    mmA = b_q;
    mmB = b_q;
    case (state_q)
      REDUCE:  mmA = ONE;
      MUL:     mmA = acc_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    exp_d    = exp_q;
    n_d      = n_q;
    res_d    = res_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    issued_d = issued_q;
    mmStart  = 1'b0;
`ifdef MODEXP_CONST_TIME_EN
    bitCnt_d = bitCnt_q;
`endif
    if ((state_q == REDUCE || state_q == MUL || state_q == SQR) && !issued_q) begin
      mmStart  = 1'b1;
      issued_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          b_d    = base;
          exp_d  = exp;
          n_d    = n;
          busy_d = 1'b1;
          err_d  = 1'b0;
          if (n <= ONE) begin
            acc_d   = '0;
            state_d = FIN;
          end else begin
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        if (mmDone) begin
          issued_d = 1'b0;
          b_d      = mmP;
          acc_d    = ONE;
`ifdef MODEXP_CONST_TIME_EN
          bitCnt_d = '0;
          state_d  = MUL;
`else
          if (exp_q == '0)  state_d = FIN;
          else if (exp_q[0]) state_d = MUL;
          else               state_d = SQR;
`endif
        end
      end
      MUL: begin
        if (mmDone) begin
          issued_d = 1'b0;
`ifdef MODEXP_CONST_TIME_EN
          if (exp_q[0]) acc_d = mmP;
`else
          acc_d = mmP;
`endif
          state_d = SQR;
        end
      end
      SQR: begin
        if (mmDone) begin
          issued_d = 1'b0;
          b_d      = mmP;
          exp_d    = remaining;
`ifdef MODEXP_CONST_TIME_EN
          if (bitCnt_q == LAST_BIT) begin
            state_d = FIN;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
            state_d  = MUL;
          end
`else
          if (remaining == '0)   state_d = FIN;
          else if (remaining[0]) state_d = MUL;
          else                   state_d = SQR;
`endif
        end
      end
      FIN: begin
        res_d   = acc_q;
        err_d   = (n_q == '0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      issued_q <= 1'b0;
`ifdef MODEXP_CONST_TIME_EN
      bitCnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      issued_q <= issued_d;
`ifdef MODEXP_CONST_TIME_EN
      bitCnt_q <= bitCnt_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
  assign err  = err_q;

endmodule

// File: tb/tb_modexp.sv
// Directed bench for modexp at W=8 plus a short W=64 random sweep against a behavioural model.
module tb_modexp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base = '0, exp = '0, n = '0;
  logic       busy, done, err;
  logic [7:0] res;

  logic        start64 = 1'b0;
  logic [63:0] base64 = '0, exp64 = '0, n64 = '0;
  logic        busy64, done64, err64;
  logic [63:0] res64;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  modexp #(.mbit(7)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .n(n),
    .busy(busy), .done(done), .res(res), .err(err)
  );

  modexp #(.mbit(63)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .base(base64), .exp(exp64), .n(n64),
    .busy(busy64), .done(done64), .res(res64), .err(err64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected start-to-done latency for n >= 2, from the architectural formula.
  function automatic int expLatency(input logic [7:0] e);
    int pop = 0;
    int len = 0;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) begin
        pop++;
        len = i + 1;
      end
    end
`ifdef MODEXP_CONST_TIME_EN
    return (2 * 8 + 1) * (8 + 1) + 2;
`else
    return (1 + pop + len) * (8 + 1) + 2;
`endif
  endfunction

  function automatic logic [63:0] refPow(input logic [63:0] b, input logic [63:0] e,
                                         input logic [63:0] m);
    logic [127:0] r, x, mm;
    mm = {64'd0, m};
    r  = 128'd1 % mm;
    x  = {64'd0, b} % mm;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[63:0];
  endfunction

  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                               input bit disturb, output logic [7:0] r, output logic er,
                               output int lat);
    @(negedge clk);
    base = b; exp = e; n = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    checkOutput("busy_high", {63'd0, busy}, 64'd1);
    while (!done && lat < 400) begin
      if (disturb && lat == 5) begin
        start = 1'b1; base = 8'hFF; exp = 8'h03; n = 8'h07;
      end else if (disturb && lat == 6) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    checkOutput("done_seen", {63'd0, done}, 64'd1);
    r  = res;
    er = err;
    @(negedge clk);
    checkOutput("done_width", {63'd0, done}, 64'd0);
  endtask

  task automatic applyStimulus64(input logic [63:0] b, input logic [63:0] e,
                                 input logic [63:0] m);
    int lat;
    @(negedge clk);
    base64 = b; exp64 = e; n64 = m; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    lat = 1;
    while (!done64 && lat < 9000) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("w64_done_seen", {63'd0, done64}, 64'd1);
    checkOutput("w64_res", res64, refPow(b, e, m));
    @(negedge clk);
    checkOutput("w64_done_width", {63'd0, done64}, 64'd0);
  endtask

  initial begin
    logic [7:0] r;
    logic       er;
    int         lat;
    logic [63:0] rb, re, rn;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_res",  {56'd0, res},  64'd0);
    checkOutput("reset_err",  {63'd0, err},  64'd0);
    rst = 1'b0;

    applyStimulus(8'd4, 8'd13, 8'd197, 1'b0, r, er, lat);
    checkOutput("pow_4_13_197", {56'd0, r}, 64'd26);
    checkOutput("pow_4_13_197_err", {63'd0, er}, 64'd0);
    checkOutput("pow_4_13_197_lat", 64'(lat), 64'(expLatency(8'd13)));

    applyStimulus(8'd9, 8'd7, 8'd143, 1'b0, r, er, lat);
    checkOutput("rsa_encrypt", {56'd0, r}, 64'd48);
    applyStimulus(8'd48, 8'd103, 8'd143, 1'b0, r, er, lat);
    checkOutput("rsa_decrypt", {56'd0, r}, 64'd9);
    checkOutput("rsa_decrypt_lat", 64'(lat), 64'(expLatency(8'd103)));

    applyStimulus(8'd200, 8'd1, 8'd143, 1'b0, r, er, lat);
    checkOutput("base_ge_n", {56'd0, r}, 64'd57);
    applyStimulus(8'd5, 8'd0, 8'd143, 1'b0, r, er, lat);
    checkOutput("exp_zero", {56'd0, r}, 64'd1);
    checkOutput("exp_zero_lat", 64'(lat), 64'(expLatency(8'd0)));
    applyStimulus(8'd5, 8'd3, 8'd1, 1'b0, r, er, lat);
    checkOutput("n_one", {56'd0, r}, 64'd0);
    checkOutput("n_one_err", {63'd0, er}, 64'd0);
    applyStimulus(8'd5, 8'd3, 8'd0, 1'b0, r, er, lat);
    checkOutput("n_zero", {56'd0, r}, 64'd0);
    checkOutput("n_zero_err", {63'd0, er}, 64'd1);

    applyStimulus(8'd4, 8'd13, 8'd197, 1'b1, r, er, lat);
    checkOutput("start_while_busy", {56'd0, r}, 64'd26);
    checkOutput("start_while_busy_lat", 64'(lat), 64'(expLatency(8'd13)));

    // Reset lands during the first squaring of 4^13 mod 197.
    @(negedge clk);
    base = 8'd4; exp = 8'd13; n = 8'd197; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst_done", {63'd0, done}, 64'd0);
    checkOutput("midrst_res",  {56'd0, res},  64'd0);
    applyStimulus(8'd9, 8'd7, 8'd143, 1'b0, r, er, lat);
    checkOutput("after_midrst", {56'd0, r}, 64'd48);

    for (int i = 0; i < 5; i++) begin
      rb = {$urandom, $urandom};
      re = {$urandom, $urandom};
      rn = {$urandom, $urandom} | 64'd2;
      applyStimulus64(rb, re, rn);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
